// File: rtl/nanorv32_seqdiv_if.sv
// Divide request/response handshake between the mul-div stage (master) and
// the sequential divider (slave).
interface nanorv32_seqdiv_if #(
  parameter int unsigned NANORV32_DATA_MSB = 31
);
  logic                         req_valid;
  logic                         req_ready;
  logic [NANORV32_DATA_MSB:0]   req_in_1;
  logic [NANORV32_DATA_MSB:0]   req_in_2;
  logic                         req_in_1_signed;
  logic                         req_in_2_signed;
  logic                         rem_op_sel;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [NANORV32_DATA_MSB:0]   resp_result;

  modport master (
    output req_valid, req_in_1, req_in_2, req_in_1_signed, req_in_2_signed,
           rem_op_sel, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_in_1, req_in_2, req_in_1_signed, req_in_2_signed,
           rem_op_sel, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/nanorv32_seqdiv.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define NANORV32_DIV_EARLY_OUT_EN to finish divide-by-zero and |a|<|b| in one cycle.
module nanorv32_seqdiv #(
  parameter int unsigned NANORV32_DATA_MSB = 31
) (
  input  logic             clk,
  input  logic             rst,
  nanorv32_seqdiv_if.slave div_if
);
  localparam int unsigned DW = NANORV32_DATA_MSB + 1;
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW-1:0]   res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            rsel_q, rsel_d;
  logic            rdy_q, rdy_d;
  logic            vld_q, vld_d;

  logic            sign1, sign2, dvs_zero;
  logic [DW-1:0]   mag1, mag2;
  logic [DW:0]     rem_sh, trial;
  logic [DW-1:0]   quo_sh;

  // Operand magnitudes; only signed operands with the MSB set are negated
  assign sign1    = div_if.req_in_1[DW-1] & div_if.req_in_1_signed;
  assign sign2    = div_if.req_in_2[DW-1] & div_if.req_in_2_signed;
  assign mag1     = sign1 ? DW'(-div_if.req_in_1) : div_if.req_in_1;
  assign mag2     = sign2 ? DW'(-div_if.req_in_2) : div_if.req_in_2;
  assign dvs_zero = (div_if.req_in_2 == '0);

  assign rem_sh = {rem_q, quo_q[DW-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign quo_sh = {quo_q[DW-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rsel_d  = rsel_q;
    vld_d   = vld_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_if.req_valid) begin
          // Quotient sign fix is suppressed for divide-by-zero (result stays all-ones)
          qneg_d  = (sign1 ^ sign2) & ~dvs_zero;
          rneg_d  = sign1;
          rsel_d  = div_if.rem_op_sel;
          dvs_d   = mag2;
          quo_d   = mag1;
          rem_d   = '0;
          cnt_d   = CW'(DW - 1);
          state_d = CALC;
`ifdef NANORV32_DIV_EARLY_OUT_EN
          if (dvs_zero || (mag1 < mag2)) begin
            quo_d   = dvs_zero ? '1 : '0;
            rem_d   = mag1;
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (!trial[DW]) begin
          rem_d = trial[DW-1:0];
          quo_d = quo_sh | DW'(1);
        end else begin
          rem_d = rem_sh[DW-1:0];
          quo_d = quo_sh;
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        if (rsel_q) begin
          res_d = rneg_q ? DW'(-rem_q) : rem_q;
        end else begin
          res_d = qneg_q ? DW'(-quo_q) : quo_q;
        end
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (div_if.resp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rsel_q  <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      rsel_q  <= rsel_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign div_if.req_ready   = rdy_q;
  assign div_if.resp_valid  = vld_q;
  assign div_if.resp_result = res_q;
endmodule
